bin2bcd_seq: RTL
================

Name: bin2bcd_seq

Overview:
- Sequential shift-and-add-3 (double-dabble) converter: unsigned binary word in, packed multi-digit BCD out.
- Sits directly upstream of the per-digit BCD-to-7-segment decoders; each 4-bit digit slice drives one decoder's 4-bit BCD input.
- start/busy/done handshake; holds last result stable between conversions.
- Optional leading-zero blanking emits code 4'hF, which the downstream decoder maps to all segments off.

Parameters:
- BIN_W, 10, width of binary input; range 1..20.
- DIGITS, 4, number of BCD digits produced; range 1..6.
- LZ_BLANK, 1, 1 = replace leading zero digits (never digit 0) with 4'hF; 0 = output raw zeros.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request conversion; sampled only in IDLE.
- bin_in  input  BIN_W  unsigned value; captured on the accepting edge only.
- busy  output  1  high while conversion is in progress.
- done  output  1  one-cycle pulse; bcd_out/overflow valid from this cycle on.
- overflow  output  1  bin_in exceeded 10^DIGITS-1; held with result.
- bcd_out  output  4*DIGITS  packed digits, digit 0 (units) at [3:0], digit k at [4k+3:4k].

Behaviour:
- Reset (rst=1 at an edge): state IDLE, busy=0, done=0, overflow=0, bcd_out all zeros ("0...0", no blanking applied). Reset has priority over everything and aborts any conversion in flight; no done pulse for an aborted conversion.
- FSM states: IDLE, SHIFT.
- IDLE, start=1 at edge E0:
  - load shift reg = bin_in, scratch digits = 0, count = BIN_W;
  - compute ovf_pending = (bin_in > 10^DIGITS-1);
  - busy=1, go to SHIFT.
- IDLE, start=0: hold all outputs; done=0.
- SHIFT, each edge:
  - every scratch digit >= 5 gets +3 (4-bit, no carry out);
  - then {scratch, shift reg} shifts left by 1;
  - count decrements.
- On the edge where count goes 1 -> 0 (edge E0+BIN_W):
  - bcd_out <= final digits, with blanking if LZ_BLANK;
  - overflow <= ovf_pending;
  - done <= 1, busy <= 0, state IDLE.
  - If overflow, bcd_out = all digits 9 (saturate), blanking not applied.
- Latency: done high in the cycle after edge E0+BIN_W; busy high for exactly BIN_W cycles.
- done deasserts on the next edge unconditionally.
- start while busy: ignored, no queuing.
- start during the done cycle (FSM in IDLE): accepted; back-to-back throughput is one result per BIN_W+1 cycles.
- bcd_out and overflow change only on a done edge or reset; stable at all other times, including during a conversion.
- Scratch digit width: 4*DIGITS bits; bits shifted out past the top digit are discarded (overflow is covered by ovf_pending).
- Blanking rule, LZ_BLANK=1:
  - scan from the most significant digit down; each zero digit becomes 4'hF until the first nonzero digit;
  - digit 0 is always shown, so value 0 displays as units "0".
- Elaboration check: ceil(BIN_W*log10(2)) > DIGITS is legal, since overflow handles it; DIGITS=0 or BIN_W=0 is a fatal elaboration error.

Decomposition:
- Package bcd_pkg:
  - DIGIT_W=4;
  - BLANK_CODE=4'hF;
  - constant function pow10(n) used for the overflow limit;
  - FSM state enum {IDLE, SHIFT}.
- Sub-module bcd_add3: combinational 4-bit digit correction (in >= 5 ? in+3 : in), instantiated DIGITS times in a generate loop.
- Blanking and saturation are in the top block.

Test Plan:
- Default params, bin_in=1023, start 1 cycle -> busy high 10 cycles, done pulse 1 cycle, bcd_out=16'h1023, overflow=0.
- Default params, bin_in=0 -> bcd_out=16'hFFF0. With LZ_BLANK=0, bin_in=7 -> 16'h0007. With LZ_BLANK=1, bin_in=40 -> 16'hFF40.
- DIGITS=3, BIN_W=10, bin_in=1000 -> overflow=1, bcd_out=12'h999. Next conversion of bin_in=5 -> overflow=0, bcd_out=12'hFF5.
- Conversion of 512 running; start pulsed with bin_in=99 at cycle 4 of busy -> ignored, result 16'h0512 with LZ_BLANK=0. Start held during the done cycle with bin_in=99 -> accepted, next result 16'hFF99.
- rst asserted at cycle 5 of a conversion -> next cycle busy=0, bcd_out=0, no done pulse. Fresh start of 321 afterwards -> 16'hF321.
- Random sweep of 0..1023, compared against a reference model -> all match; done pulses exactly BIN_W+1 cycles apart under continuous start.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   DIGIT_W    : width of one BCD digit
//   BLANK_CODE : digit code the 7-segment decoder renders as all segments off
//   pow10()    : elaboration-time power of ten, used for the overflow limit
//   state_t    : converter FSM states
package bcd_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam logic [3:0]  BLANK_CODE = 4'hF;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
//   digit_in  : current scratch digit
//   digit_out : corrected digit (4-bit wrap, no carry out)
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    always_comb begin
        digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to packed BCD converter with a
// start/busy/done handshake, overflow saturation and optional leading-zero
// blanking for the downstream 7-segment decoders.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   start    : conversion request, sampled only in IDLE
//   bin_in   : unsigned binary value, captured on the accepting edge
//   busy     : high while a conversion is in progress
//   done     : one-cycle pulse when bcd_out/overflow are updated
//   overflow : bin_in exceeded 10^DIGITS-1 (held with the result)
//   bcd_out  : packed digits, units at [3:0]; held between conversions
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W    = 10,
    parameter int DIGITS   = 4,
    parameter int LZ_BLANK = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int         SCR_W = int'(DIGIT_W) * DIGITS;
    localparam int         CNT_W = $clog2(BIN_W + 1);
    localparam logic [31:0] LIMIT = 32'(pow10(DIGITS) - 1);

    generate
        if (BIN_W < 1 || BIN_W > 20 || DIGITS < 1 || DIGITS > 6) begin : g_bad_params
            $fatal(1, "bin2bcd_seq: BIN_W must be 1..20 and DIGITS 1..6");
        end
    endgenerate

    state_t              state_q;
    state_t              state_d;
    logic [BIN_W-1:0]    shift_q;
    logic [SCR_W-1:0]    scr_q;
    logic [SCR_W-1:0]    scr_corr;
    logic [SCR_W-1:0]    scr_next;
    logic [SCR_W-1:0]    shown;
    logic [SCR_W-1:0]    result_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [31:0]         bin_ext;
    logic                ovf_pend_q;
    logic                load;
    logic                step;
    logic                finish;
    logic                leading;

    // Per-digit add-3 correction applied before every shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_in  (scr_q[g*DIGIT_W +: DIGIT_W]),
            .digit_out (scr_corr[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Bits leaving the top digit are dropped; overflow is flagged separately.
    always_comb begin
        scr_next = SCR_W'({scr_corr, shift_q[BIN_W-1]});
        bin_ext  = 32'(bin_in);
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        busy    = (state_q == SHIFT);
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Blanking scans from the top digit down and stops at the first nonzero
    // digit; digit 0 is never blanked. Saturation overrides blanking.
    always_comb begin
        shown   = scr_next;
        leading = 1'b1;
        if (LZ_BLANK != 0) begin
            for (int unsigned i = 0; i < DIGITS - 1; i++) begin
                if (leading && shown[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] == '0) begin
                    shown[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] = BLANK_CODE;
                end else begin
                    leading = 1'b0;
                end
            end
        end
        result_d = ovf_pend_q ? {DIGITS{4'h9}} : shown;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            bcd_out    <= '0;
        end else begin
            state_q <= state_d;
            done    <= finish;
            if (load) begin
                shift_q    <= bin_in;
                scr_q      <= '0;
                cnt_q      <= CNT_W'(BIN_W);
                ovf_pend_q <= (bin_ext > LIMIT);
            end else if (step) begin
                shift_q <= shift_q << 1;
                scr_q   <= scr_next;
                cnt_q   <= cnt_q - CNT_W'(1);
            end
            if (finish) begin
                bcd_out  <= result_d;
                overflow <= ovf_pend_q;
            end
        end
    end

endmodule
